store_burst_sequencer: RTL and testbench

- Downstream of the store-control state machine: consumes its level-held `swEnable` and performs the actual memory writes.
- Walks a contiguous address range, copying register-file words into data memory with a ready/ack handshake.
- Returns a one-cycle `storeEnd` pulse so the store FSM can drop back to IDLE.

---
 rtl/store_burst_sequencer.sv | 148 ++++++++++++++
 tb/tb_store_burst_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_burst_sequencer.sv
// Store burst sequencer: copies register-file words into data memory over a ready/ack write handshake.
// Optional macro STORE_BOUNDS_CHECK_EN adds addrLimit/boundsErr range checking at start.
module store_burst_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              swEnable,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic [CNT_W-1:0]  wordCount,
  input  logic [DATA_W-1:0] regData,
  input  logic              memAck,
`ifdef STORE_BOUNDS_CHECK_EN
  input  logic [ADDR_W-1:0] addrLimit,
  output logic              boundsErr,
`endif
  output logic [CNT_W-1:0]  regIdx,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memData,
  output logic              memWe,
  output logic              storeEnd,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [CNT_W-1:0]  idx_r, idx_s;
  logic              start_err_s;

`ifdef STORE_BOUNDS_CHECK_EN
  logic              bounds_err_r, bounds_err_s;
  logic [ADDR_W:0]   last_addr_s;

  // Last address of the burst, one bit wider so a wrap past the top shows up as overflow.
  always_comb begin
    last_addr_s = {1'b0, baseAddr} + {{(ADDR_W+1-CNT_W){1'b0}}, wordCount} - {{ADDR_W{1'b0}}, 1'b1};
    if (wordCount == {CNT_W{1'b0}}) begin
      start_err_s = 1'b0;
    end else begin
      start_err_s = last_addr_s[ADDR_W] || (last_addr_s > {1'b0, addrLimit});
    end
  end

  assign boundsErr = bounds_err_r;
`else
  assign start_err_s = 1'b0;
`endif

  // Next-state and datapath update decode.
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
`ifdef STORE_BOUNDS_CHECK_EN
    bounds_err_s = bounds_err_r;
`endif
    case (state_r)
      IDLE: begin
        if (swEnable) begin
          addr_s = baseAddr;
          cnt_s  = wordCount;
          idx_s  = {CNT_W{1'b0}};
`ifdef STORE_BOUNDS_CHECK_EN
          bounds_err_s = start_err_s;
`endif
          if ((wordCount == {CNT_W{1'b0}}) || start_err_s) begin
            state_s = DONE;
          end else begin
            state_s = ISSUE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        // An ack in an abort cycle still advances the pointers; IDLE never looks at them.
        if (memAck) begin
          addr_s = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          idx_s  = idx_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          addr_s = addr_r;
          idx_s  = idx_r;
        end
        if (!swEnable) begin
          state_s = IDLE;
        end else if (memAck && (idx_r == (cnt_r - {{(CNT_W-1){1'b0}}, 1'b1}))) begin
          state_s = DONE;
        end else begin
          state_s = ISSUE;
        end
      end
      DONE: begin
        state_s = RELEASE;
      end
      RELEASE: begin
        // Wait for the enable level to drop so a held swEnable cannot retrigger.
        if (!swEnable) begin
          state_s = IDLE;
        end else begin
          state_s = RELEASE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_r <= IDLE;
      addr_r  <= {ADDR_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      idx_r   <= {CNT_W{1'b0}};
`ifdef STORE_BOUNDS_CHECK_EN
      bounds_err_r <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
`ifdef STORE_BOUNDS_CHECK_EN
      bounds_err_r <= bounds_err_s;
`endif
    end
  end

  assign memWe    = (state_r == ISSUE);
  assign storeEnd = (state_r == DONE);
  assign busy     = (state_r != IDLE);
  assign memAddr  = addr_r;
  assign regIdx   = idx_r;
  assign memData  = memWe ? regData : {DATA_W{1'b0}};

endmodule

// File: tb/tb_store_burst_sequencer.sv
// Directed self-checking bench for store_burst_sequencer; regData is a fixed function of regIdx.
module tb_store_burst_sequencer;

  logic        clk;
  logic        rstN;
  logic        swEnable;
  logic [7:0]  baseAddr;
  logic [3:0]  wordCount;
  logic [15:0] regData;
  logic        memAck;
  logic [3:0]  regIdx;
  logic [7:0]  memAddr;
  logic [15:0] memData;
  logic        memWe;
  logic        storeEnd;
  logic        busy;
`ifdef STORE_BOUNDS_CHECK_EN
  logic [7:0]  addrLimit;
  logic        boundsErr;
`endif

  int checks;
  int errors;
  int wr_cnt;
  int end_cnt;
  int wr_base;
  int end_base;

  store_burst_sequencer #(.ADDR_W(8), .DATA_W(16), .CNT_W(4)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .swEnable  (swEnable),
    .baseAddr  (baseAddr),
    .wordCount (wordCount),
    .regData   (regData),
    .memAck    (memAck),
`ifdef STORE_BOUNDS_CHECK_EN
    .addrLimit (addrLimit),
    .boundsErr (boundsErr),
`endif
    .regIdx    (regIdx),
    .memAddr   (memAddr),
    .memData   (memData),
    .memWe     (memWe),
    .storeEnd  (storeEnd),
    .busy      (busy)
  );

  assign regData = 16'hA500 ^ {12'h000, regIdx};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accepted writes and completion pulses as seen by the memory side.
  always @(posedge clk) begin
    if (rstN && memWe && memAck) wr_cnt <= wr_cnt + 1;
    if (rstN && storeEnd) end_cnt <= end_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_write(input string tag, input logic [7:0] addr, input logic [3:0] idx);
    logic [15:0] d;
    d = 16'hA500 ^ {12'h000, idx};
    check({tag, "_we"}, {31'd0, memWe}, 32'd1);
    check({tag, "_addr"}, {24'd0, memAddr}, {24'd0, addr});
    check({tag, "_idx"}, {28'd0, regIdx}, {28'd0, idx});
    check({tag, "_data"}, {16'd0, memData}, {16'd0, d});
  endtask

  task automatic check_done(input string tag);
    check({tag, "_done_we"}, {31'd0, memWe}, 32'd0);
    check({tag, "_done_end"}, {31'd0, storeEnd}, 32'd1);
    check({tag, "_done_busy"}, {31'd0, busy}, 32'd1);
    step();
    check({tag, "_rel_end"}, {31'd0, storeEnd}, 32'd0);
    check({tag, "_rel_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_rel_we"}, {31'd0, memWe}, 32'd0);
    step();
    check({tag, "_hold_busy"}, {31'd0, busy}, 32'd1);
    swEnable = 1'b0;
    step();
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] a;
    checks = 0; errors = 0; wr_cnt = 0; end_cnt = 0;
    rstN = 1'b0; swEnable = 1'b0; baseAddr = 8'h00; wordCount = 4'd0; memAck = 1'b0;
`ifdef STORE_BOUNDS_CHECK_EN
    addrLimit = 8'hFF;
`endif
    #23;
    check("rst_we", {31'd0, memWe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_end", {31'd0, storeEnd}, 32'd0);
    check("rst_addr", {24'd0, memAddr}, 32'd0);
    check("rst_idx", {28'd0, regIdx}, 32'd0);
    rstN = 1'b1;
    step();

    // Test 1: three back-to-back writes
    wr_base = wr_cnt; end_base = end_cnt;
    baseAddr = 8'h10; wordCount = 4'd3; memAck = 1'b1; swEnable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_write("t1", 8'h10 + 8'(i), 4'(i));
    end
    step();
    check_done("t1");
    check("t1_wr_cnt", 32'(wr_cnt - wr_base), 32'd3);
    check("t1_end_cnt", 32'(end_cnt - end_base), 32'd1);

    // Test 2: ack delayed two cycles per word
    wr_base = wr_cnt; end_base = end_cnt;
    baseAddr = 8'h40; wordCount = 4'd2; memAck = 1'b0; swEnable = 1'b1;
    step();
    for (int w = 0; w < 2; w++) begin
      check_write("t2_wait0", 8'h40 + 8'(w), 4'(w));
      step();
      check_write("t2_wait1", 8'h40 + 8'(w), 4'(w));
      step();
      check_write("t2_wait2", 8'h40 + 8'(w), 4'(w));
      memAck = 1'b1;
      step();
      memAck = 1'b0;
    end
    check_done("t2");
    check("t2_wr_cnt", 32'(wr_cnt - wr_base), 32'd2);
    check("t2_end_cnt", 32'(end_cnt - end_base), 32'd1);

    // Test 3: burst across the top of the address space
    wr_base = wr_cnt;
    baseAddr = 8'hFE; wordCount = 4'd4; memAck = 1'b1; swEnable = 1'b1;
`ifdef STORE_BOUNDS_CHECK_EN
    addrLimit = 8'hFF;
    step();
    check("t3_err", {31'd0, boundsErr}, 32'd1);
    check_done("t3");
    check("t3_err_held", {31'd0, boundsErr}, 32'd1);
    check("t3_wr_cnt", 32'(wr_cnt - wr_base), 32'd0);
`else
    for (int i = 0; i < 4; i++) begin
      step();
      a = 8'hFE + 8'(i);
      check_write("t3", a, 4'(i));
    end
    step();
    check_done("t3");
    check("t3_wr_cnt", 32'(wr_cnt - wr_base), 32'd4);
`endif

    // Test 4: zero-length store
    wr_base = wr_cnt;
    baseAddr = 8'h33; wordCount = 4'd0; memAck = 1'b1; swEnable = 1'b1;
    step();
`ifdef STORE_BOUNDS_CHECK_EN
    check("t4_err", {31'd0, boundsErr}, 32'd0);
`endif
    check_done("t4");
    check("t4_wr_cnt", 32'(wr_cnt - wr_base), 32'd0);

    // Test 5: abort after the second ack, then a fresh start
    end_base = end_cnt;
    baseAddr = 8'h80; wordCount = 4'd5; memAck = 1'b1; swEnable = 1'b1;
    step();
    check_write("t5_w0", 8'h80, 4'd0);
    step();
    check_write("t5_w1", 8'h81, 4'd1);
    step();
    swEnable = 1'b0;
    step();
    check("t5_ab_we", {31'd0, memWe}, 32'd0);
    check("t5_ab_busy", {31'd0, busy}, 32'd0);
    check("t5_ab_end", {31'd0, storeEnd}, 32'd0);
    check("t5_end_cnt", 32'(end_cnt - end_base), 32'd0);
    baseAddr = 8'h20; wordCount = 4'd1; swEnable = 1'b1;
    step();
    check_write("t5_new", 8'h20, 4'd0);
    step();
    check_done("t5");

    // Test 6: asynchronous reset mid-burst with swEnable held
    baseAddr = 8'h30; wordCount = 4'd4; memAck = 1'b1; swEnable = 1'b1;
    step();
    step();
    check_write("t6_pre", 8'h31, 4'd1);
    #2 rstN = 1'b0;
    #1;
    check("t6_rst_we", {31'd0, memWe}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_end", {31'd0, storeEnd}, 32'd0);
    check("t6_rst_addr", {24'd0, memAddr}, 32'd0);
    baseAddr = 8'h50; wordCount = 4'd1;
    #1 rstN = 1'b1;
    step();
    check_write("t6_new", 8'h50, 4'd0);
    step();
    check_done("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
